mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
// - Shares one single-ported memory between the CPU instruction-fetch port and the load/store port.
// - Sits between the RV32I core and the unified memory. Sequences each access as a req/ack
//   transaction and raises stall to freeze the core's pc until all its requests are acknowledged.
// - Checks access size/alignment and bounds memory wait states with a watchdog.
// PARAMETERS
// - ADDR_W    32  address width, both requesters and memory
// - DATA_W    32  data width
// - MAX_WAIT  15  max consecutive mem_ready=0 cycles in a busy state before forced error termination
// PORTS
// - clk        in   1       single clock; all state updates on posedge clk
// - rst_n      in   1       asynchronous, active-low reset
// - if_req     in   1       instruction fetch request; held with if_addr until if_ack
// - if_addr    in   ADDR_W  fetch address; must be word aligned
// - if_rdata   out  DATA_W  fetched instruction; valid in the if_ack cycle
// - if_ack     out  1       1-cycle pulse, fetch complete
// - if_err     out  1       with if_ack: misaligned fetch or timeout
// - d_req      in   1       load/store request; held with d_* until d_ack
// - d_we       in   1       1 = store, 0 = load
// - d_size     in   2       00 byte, 01 half, 10 word, 11 illegal
// - d_addr     in   ADDR_W  data address
// - d_wdata    in   DATA_W  store data
// - d_rdata    out  DATA_W  load data; valid in the d_ack cycle
// - d_ack      out  1       1-cycle pulse, data access complete
// - d_err      out  1       with d_ack: illegal size, misaligned access or timeout
// - mem_en     out  1       memory access strobe; held until mem_ready or timeout
// - mem_we     out  1       memory write enable
// - mem_size   out  2       access size to memory, same encoding as d_size
// - mem_addr   out  ADDR_W  memory address
// - mem_wdata  out  DATA_W  memory write data
// - mem_rdata  in   DATA_W  memory read data; sampled when mem_ready=1
// - mem_ready  in   1       memory completes the current access this cycle
// - stall      out  1       comb: (if_req & ~if_ack) | (d_req & ~d_ack)
// BEHAVIOUR
// - Reset: state=IDLE, wait counter=0.
//   - All registered outputs are 0: *_ack, *_err, *_rdata, mem_* and the mem_* latches.
//   - Reset mid-transaction abandons the access; mem_en drops immediately.
// - FSM states: IDLE, BUSY_IF, BUSY_D, ERR_RSP.
// - IDLE, at each edge:
//   - Exactly one request is selected; d wins over if by default.
//   - If the selected request is illegal (size 11; half with addr[0]=1; word or fetch with
//     addr[1:0]!=0), go to ERR_RSP.
//   - Otherwise latch addr/we/size/wdata into the mem_* registers (fetch: we=0, size=10) and go to
//     BUSY_IF or BUSY_D.
// - BUSY_x:
//   - mem_en=1 and mem_* are stable throughout.
//   - On an edge with mem_ready=1: capture mem_rdata into x_rdata, pulse x_ack=1 next cycle, drop
//     mem_en, go to IDLE.
//   - On an edge with mem_ready=0: wait counter +1.
//   - When the counter equals MAX_WAIT: x_ack=1, x_err=1, x_rdata=0, go to IDLE. No mem_ready is
//     accepted after that.
// - ERR_RSP: x_ack=1, x_err=1, x_rdata=0 for one cycle, no memory access, then IDLE.
// - Latency: req in cycle 0, mem_en in cycle 1, zero-wait mem_ready in cycle 1, ack in cycle 2.
//   Each wait state adds 1 cycle.
// - Ack cycle is spent in IDLE, where new requests are arbitrated. A requester must drop req in its
//   ack cycle unless it presents a new transaction. A held req is taken as back-to-back.
// - Wait counter is 4+ bits, clears on entering BUSY_x, never wraps.
// - Stores: d_rdata=0 at ack.
// - Requests arriving while busy wait; their inputs are not sampled until granted.
// - Both requests high in the same IDLE cycle: one grant only; the other is served in a later IDLE.
// CONFIGURATION
// - ARB_FAIRNESS_EN defined:
//   - A last_grant flag updates on every grant.
//   - With both requests pending in IDLE and last_grant=d, if wins. Otherwise d wins.
//   - Guarantees each requester at most one grant of delay.
// - ARB_FAIRNESS_EN undefined:
//   - Fixed priority, d over if.
//   - A continuously held d_req starves fetch; accepted because the core stalls fetch during loads
//     and stores.
// TESTING
// - Fetch if_addr=0x100, mem_ready tied 1 -> mem_en cycle 1, mem_addr=0x100, if_ack cycle 2,
//   if_rdata=mem_rdata, stall falls in cycle 2.
// - Store d_addr=0x204, d_size=10, d_wdata=0xDEADBEEF, mem_ready after 3 waits -> mem_we=1,
//   mem_wdata=0xDEADBEEF held 4 cycles, d_ack cycle 5, d_err=0.
// - if_req and d_req together, both 0-wait -> d granted first, if_ack 2 cycles after d_ack.
//   With ARB_FAIRNESS_EN and d_req held: grants alternate d, if, d.
// - d_size=11, or half with d_addr=0x3 -> mem_en stays 0, d_ack=d_err=1 in cycle 2, d_rdata=0.
// - mem_ready stuck 0 -> mem_en high MAX_WAIT cycles, then ack+err, mem_en=0, FSM back in IDLE.
// - rst_n low while in BUSY_D -> mem_en, d_ack and stall-side regs drop at once. After release, a
//   fetch completes normally in 2 cycles.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, load/store and memory-side signals of the memory port arbiter
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ack;
  logic              if_err;
  logic              d_req;
  logic              d_we;
  logic [1:0]        d_size;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ack;
  logic              d_err;
  logic              mem_en;
  logic              mem_we;
  logic [1:0]        mem_size;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
  logic              stall;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_size, d_addr, d_wdata, mem_rdata, mem_ready,
    output if_rdata, if_ack, if_err, d_rdata, d_ack, d_err,
    output mem_en, mem_we, mem_size, mem_addr, mem_wdata, stall
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_size, d_addr, d_wdata, mem_rdata, mem_ready,
    input  if_rdata, if_ack, if_err, d_rdata, d_ack, d_err,
    input  mem_en, mem_we, mem_size, mem_addr, mem_wdata, stall
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and load/store; optional ARB_FAIRNESS_EN alternates grants
module mem_port_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mem_port_arbiter_if.slave    bus
);
  localparam int CNT_W = ($clog2(MAX_WAIT + 1) > 4) ? $clog2(MAX_WAIT + 1) : 4;

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D, ERR_RSP} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              err_d;
  logic              pick_d;
  logic              any_req;
  logic              d_bad;
  logic              if_bad;
  logic              sel_bad;
  logic              done;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

`ifdef ARB_FAIRNESS_EN
  logic last_d;
  assign pick_d = bus.d_req & ~(bus.if_req & last_d);
  // remember who won the last grant so a contested IDLE goes the other way
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) last_d <= 1'b0;
    else if (state == IDLE && any_req) last_d <= pick_d;
`else
  assign pick_d = bus.d_req;
`endif

  assign bus.stall = (bus.if_req & ~bus.if_ack) | (bus.d_req & ~bus.d_ack);

  // request legality, selected request fields and busy-state completion
  always_comb begin
    any_req   = bus.if_req | bus.d_req;
    d_bad     = (bus.d_size == 2'b11) | ((bus.d_size == 2'b01) & bus.d_addr[0]) |
                ((bus.d_size == 2'b10) & (|bus.d_addr[1:0]));
    if_bad    = |bus.if_addr[1:0];
    sel_bad   = pick_d ? d_bad : if_bad;
    sel_addr  = pick_d ? bus.d_addr : bus.if_addr;
    sel_wdata = pick_d ? bus.d_wdata : {DATA_W{1'b0}};
    done      = bus.mem_ready | (cnt == CNT_W'(MAX_WAIT - 1));
  end

  // arbitration FSM with registered acks, read data and memory strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      err_d         <= 1'b0;
      bus.if_ack    <= 1'b0;
      bus.if_err    <= 1'b0;
      bus.if_rdata  <= '0;
      bus.d_ack     <= 1'b0;
      bus.d_err     <= 1'b0;
      bus.d_rdata   <= '0;
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_size  <= 2'b00;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else begin
      bus.if_ack <= 1'b0;
      bus.if_err <= 1'b0;
      bus.d_ack  <= 1'b0;
      bus.d_err  <= 1'b0;
      case (state)
        IDLE: if (any_req) begin
          err_d <= pick_d;
          if (sel_bad) state <= ERR_RSP;
          else begin
            state         <= pick_d ? BUSY_D : BUSY_IF;
            cnt           <= '0;
            bus.mem_en    <= 1'b1;
            bus.mem_we    <= pick_d & bus.d_we;
            bus.mem_size  <= pick_d ? bus.d_size : 2'b10;
            bus.mem_addr  <= sel_addr;
            bus.mem_wdata <= sel_wdata;
          end
        end
        BUSY_IF, BUSY_D: begin
          cnt <= bus.mem_ready ? cnt : cnt + 1'b1;
          if (done) begin
            state      <= IDLE;
            bus.mem_en <= 1'b0;
            if (state == BUSY_D) begin
              bus.d_ack   <= 1'b1;
              bus.d_err   <= ~bus.mem_ready;
              bus.d_rdata <= (bus.mem_ready & ~bus.mem_we) ? bus.mem_rdata : '0;
            end else begin
              bus.if_ack   <= 1'b1;
              bus.if_err   <= ~bus.mem_ready;
              bus.if_rdata <= bus.mem_ready ? bus.mem_rdata : '0;
            end
          end
        end
        ERR_RSP: begin
          state <= IDLE;
          if (err_d) begin
            bus.d_ack   <= 1'b1;
            bus.d_err   <= 1'b1;
            bus.d_rdata <= '0;
          end else begin
            bus.if_ack   <= 1'b1;
            bus.if_err   <= 1'b1;
            bus.if_rdata <= '0;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed table, corner sequences and random traffic against a transaction-level model
module tb_mem_port_arbiter;
  localparam int MAX_WAIT = 15;
  localparam logic [31:0] K = 32'h5A5A_1234;
`ifdef ARB_FAIRNESS_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  typedef struct {
    bit          use_d;
    bit          we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          waits;
    int          exp_lat;
    bit          exp_err;
    int          exp_en;
    bit          exp_rzero;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad = 0;
  bit   last_d = 1'b0;
  vec_t tbl[11];

  always #5 clk = ~clk;

  mem_port_arbiter_if bus ();
  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  // memory returns an address-derived word so misrouted addresses show up in read data
  assign bus.mem_rdata = bus.mem_addr ^ K;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic bit illegal(input bit is_d, input logic [1:0] size, input logic [31:0] addr);
    if (!is_d) return (addr % 4) != 0;
    case (size)
      2'd0: return 1'b0;
      2'd1: return (addr % 2) != 0;
      2'd2: return (addr % 4) != 0;
      default: return 1'b1;
    endcase
  endfunction

  task automatic present(input bit is_d, input bit we, input logic [1:0] size,
                         input logic [31:0] addr, input logic [31:0] wdata);
    if (is_d) begin
      bus.d_req = 1'b1; bus.d_we = we; bus.d_size = size; bus.d_addr = addr; bus.d_wdata = wdata;
    end else begin
      bus.if_req = 1'b1; bus.if_addr = addr;
    end
  endtask

  // runs one granted transaction from its request cycle to its ack, answering mem_en after `waits` cycles
  task automatic serve(input bit is_d, input bit hold, input int waits, input bit xwe,
                       input logic [1:0] xsize, input logic [31:0] xaddr, input logic [31:0] xwdata,
                       output int lat, output bit err, output logic [31:0] rdata,
                       output int en_cyc, output bit ok);
    int k = 0;
    lat = -1; err = 1'b0; rdata = 'x; en_cyc = 0; ok = 1'b1;
    last_d = is_d;
    for (int c = 1; c <= 40; c++) begin
      if (bus.mem_en) begin
        en_cyc++;
        if (bus.mem_we !== xwe || bus.mem_size !== xsize || bus.mem_addr !== xaddr ||
            (is_d && bus.mem_wdata !== xwdata)) ok = 1'b0;
        bus.mem_ready = (k == waits);
        k++;
      end
      tick();
      bus.mem_ready = 1'b0;
      if (is_d ? bus.if_ack : bus.d_ack) ok = 1'b0;
      if (is_d ? bus.d_ack : bus.if_ack) begin
        lat   = c;
        err   = is_d ? bus.d_err : bus.if_err;
        rdata = is_d ? bus.d_rdata : bus.if_rdata;
        if (!hold) begin
          if (is_d) bus.d_req = 1'b0;
          else bus.if_req = 1'b0;
        end
        break;
      end
    end
  endtask

  // model: illegal -> ack after 2 cycles; timeout -> MAX_WAIT busy cycles; else waits+1 busy cycles
  task automatic expect_txn(input bit is_d, input bit hold, input bit we, input logic [1:0] size,
                            input logic [31:0] addr, input logic [31:0] wdata, input int waits);
    bit b, to, err, ok;
    int lat, en;
    logic [31:0] rd;
    b  = illegal(is_d, size, addr);
    to = !b && waits >= MAX_WAIT;
    serve(is_d, hold, waits, is_d & we, is_d ? size : 2'b10, addr, wdata, lat, err, rd, en, ok);
    chk(is_d ? "d_lat" : "if_lat", lat, b ? 2 : (to ? MAX_WAIT + 1 : waits + 2));
    chk(is_d ? "d_err" : "if_err", 32'(err), 32'(b | to));
    chk(is_d ? "d_rdata" : "if_rdata", rd, (b || to || (is_d && we)) ? 32'h0 : addr ^ K);
    chk(is_d ? "d_mem_cycles" : "if_mem_cycles", en, b ? 0 : (to ? MAX_WAIT : waits + 1));
    chk(is_d ? "d_mem_fields" : "if_mem_fields", 32'(ok), 32'd1);
  endtask

  function automatic int rnd_wait();
    return ($urandom_range(0, 9) == 0) ? int'($urandom_range(13, 18)) : int'($urandom_range(0, 3));
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, en;
    bit err, ok, first_d, has_if, has_d, dwe;
    logic [31:0] rd, ia, da, dwd;
    logic [1:0] dsz;
    int wi, wd;

    tbl[0]  = '{0, 0, 2'd2, 32'h100, 32'h0,        0,  2, 0, 1,  0};
    tbl[1]  = '{1, 1, 2'd2, 32'h204, 32'hDEADBEEF, 3,  5, 0, 4,  1};
    tbl[2]  = '{1, 0, 2'd3, 32'h010, 32'h0,        0,  2, 1, 0,  1};
    tbl[3]  = '{1, 0, 2'd1, 32'h003, 32'h0,        0,  2, 1, 0,  1};
    tbl[4]  = '{1, 0, 2'd0, 32'h003, 32'h0,        1,  3, 0, 2,  0};
    tbl[5]  = '{1, 0, 2'd1, 32'h002, 32'h0,        0,  2, 0, 1,  0};
    tbl[6]  = '{1, 1, 2'd2, 32'h202, 32'h1234,     0,  2, 1, 0,  1};
    tbl[7]  = '{0, 0, 2'd2, 32'h102, 32'h0,        0,  2, 1, 0,  1};
    tbl[8]  = '{0, 0, 2'd2, 32'h040, 32'h0,        99, 16, 1, 15, 1};
    tbl[9]  = '{1, 0, 2'd2, 32'h300, 32'h0,        14, 16, 0, 15, 0};
    tbl[10] = '{1, 0, 2'd2, 32'h304, 32'h0,        15, 16, 1, 15, 1};

    rst_n = 1'b0;
    bus.if_req = 0; bus.if_addr = 0; bus.d_req = 0; bus.d_we = 0; bus.d_size = 0;
    bus.d_addr = 0; bus.d_wdata = 0; bus.mem_ready = 0;
    tick(); tick();
    chk("rst_if_ack", 32'(bus.if_ack), 0);
    chk("rst_d_ack", 32'(bus.d_ack), 0);
    chk("rst_errs", 32'({bus.if_err, bus.d_err}), 0);
    chk("rst_if_rdata", bus.if_rdata, 0);
    chk("rst_d_rdata", bus.d_rdata, 0);
    chk("rst_mem_ctl", 32'({bus.mem_en, bus.mem_we, bus.mem_size}), 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_stall", 32'(bus.stall), 0);
    rst_n = 1'b1;
    tick();

    // zero-wait fetch, cycle by cycle
    present(0, 0, 2'd2, 32'h100, 0);
    #1 chk("fetch_stall_c0", 32'(bus.stall), 1);
    tick();
    chk("fetch_mem_en_c1", 32'(bus.mem_en), 1);
    chk("fetch_mem_addr_c1", bus.mem_addr, 32'h100);
    chk("fetch_stall_c1", 32'(bus.stall), 1);
    bus.mem_ready = 1'b1;
    tick();
    bus.mem_ready = 1'b0;
    chk("fetch_ack_c2", 32'(bus.if_ack), 1);
    chk("fetch_rdata_c2", bus.if_rdata, 32'h100 ^ K);
    chk("fetch_stall_c2", 32'(bus.stall), 0);
    chk("fetch_mem_en_c2", 32'(bus.mem_en), 0);
    bus.if_req = 1'b0;
    last_d = 1'b0;
    tick();

    for (int i = 0; i < 11; i++) begin
      present(tbl[i].use_d, tbl[i].we, tbl[i].size, tbl[i].addr, tbl[i].wdata);
      serve(tbl[i].use_d, 0, tbl[i].waits, tbl[i].use_d & tbl[i].we,
            tbl[i].use_d ? tbl[i].size : 2'b10, tbl[i].addr, tbl[i].wdata, lat, err, rd, en, ok);
      chk($sformatf("vec%0d_lat", i), lat, tbl[i].exp_lat);
      chk($sformatf("vec%0d_err", i), 32'(err), 32'(tbl[i].exp_err));
      chk($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rzero ? 32'h0 : tbl[i].addr ^ K);
      chk($sformatf("vec%0d_mem_cycles", i), en, tbl[i].exp_en);
      chk($sformatf("vec%0d_mem_fields", i), 32'(ok), 1);
      tick();
    end

    // simultaneous requests: one grant, the other served from the first one's ack cycle
    present(0, 0, 2'd2, 32'h180, 0);
    present(1, 0, 2'd2, 32'h280, 0);
    first_d = !(FAIR && last_d);
    expect_txn(first_d, 0, 0, 2'd2, first_d ? 32'h280 : 32'h180, 0, 0);
    expect_txn(!first_d, 0, 0, 2'd2, first_d ? 32'h180 : 32'h280, 0, 0);
    tick();

    // d_req held across grants while fetch waits
    present(0, 0, 2'd2, 32'h400, 0);
    present(1, 0, 2'd2, 32'h500, 0);
    for (int g = 0; g < 3; g++) begin
      first_d = bus.d_req && (!bus.if_req || !(FAIR && last_d));
      expect_txn(first_d, first_d && g < 2, 0, 2'd2, first_d ? 32'h500 : 32'h400, 0, 0);
    end
    bus.d_req = 1'b0;
    if (bus.if_req) expect_txn(0, 0, 0, 2'd2, 32'h400, 0, 0);
    tick();

    // reset in the middle of a load abandons it
    present(1, 0, 2'd2, 32'h600, 0);
    tick();
    chk("rstmid_mem_en_busy", 32'(bus.mem_en), 1);
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_mem_en", 32'(bus.mem_en), 0);
    chk("rstmid_d_ack", 32'(bus.d_ack), 0);
    chk("rstmid_mem_we_size", 32'({bus.mem_we, bus.mem_size}), 0);
    bus.d_req = 1'b0;
    last_d = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    present(0, 0, 2'd2, 32'h700, 0);
    expect_txn(0, 0, 0, 2'd2, 32'h700, 0, 0);
    tick();

    for (int it = 0; it < 60; it++) begin
      has_if = 1'b0; has_d = 1'b0;
      case ($urandom_range(1, 3))
        1: has_if = 1'b1;
        2: has_d = 1'b1;
        default: begin has_if = 1'b1; has_d = 1'b1; end
      endcase
      ia  = ($urandom_range(0, 1023) << 2) | (($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : 0);
      da  = $urandom_range(0, 4095);
      dsz = 2'($urandom_range(0, 3));
      dwe = 1'($urandom_range(0, 1));
      dwd = $urandom;
      wi  = rnd_wait();
      wd  = rnd_wait();
      if (has_if) present(0, 0, 2'd2, ia, 0);
      if (has_d) present(1, dwe, dsz, da, dwd);
      first_d = has_d && (!has_if || !(FAIR && last_d));
      if (first_d) begin
        expect_txn(1, 0, dwe, dsz, da, dwd, wd);
        if (has_if) expect_txn(0, 0, 0, 2'd2, ia, 0, wi);
      end else begin
        expect_txn(0, 0, 0, 2'd2, ia, 0, wi);
        if (has_d) expect_txn(1, 0, dwe, dsz, da, dwd, wd);
      end
      if ($urandom_range(0, 1) == 1) tick();
    end

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
